// File: rtl/mem_pkg.sv
// Shared definitions for the memory utilities: sequencer state encoding and
// an address-width helper that never returns zero.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_skid_buf.sv
// 2-entry register FIFO with a registered head; push and pop may coincide.
// Caller guarantees no push when full and no pop when empty.
module mem_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) dout <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          dout <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; a single entry is replaced straight from din.
          if (occ == 2'd1) begin
            dout <= din;
          end else begin
            dout <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads len words from base out of a 1-cycle-latency memory; first beat 3 cycles after start.
// Full valid/ready backpressure via 2-entry buffer and issue credits. MEM_STREAM_READER_WRAP_EN: wrap addresses.
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 9,
  localparam int AW    = addr_w(DEPTH),
  localparam int LW    = addr_w(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [LW-1:0]    len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    rdaddress,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic [LW-1:0] remaining;
  logic          inflight;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          cmd_ok;
  logic          last_beat;

`ifdef MEM_STREAM_READER_WRAP_EN
  localparam bit REJECT_ERR = 1'b0;
  assign cmd_ok   = int'(len) <= DEPTH;
  assign addr_nxt = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
`else
  localparam bit REJECT_ERR = 1'b1;
  assign cmd_ok   = (int'(base) + int'(len)) <= DEPTH;
  assign addr_nxt = addr + AW'(1);
`endif

  assign rdaddress = addr;
  assign m_valid   = (occ != 2'd0);
  assign pop       = m_valid & m_ready;

  // Buffered + in-flight words after this cycle's pop must leave room for one more.
  assign issue = (state == ST_READ) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign last_beat = !inflight && pop && (occ == 2'd1);

  mem_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clock (clock),
    .reset (reset),
    .push  (inflight),
    .din   (q),
    .pop   (pop),
    .dout  (m_data),
    .occ   (occ)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (!cmd_ok) begin
              done <= 1'b1;
              err  <= REJECT_ERR;
            end else if (len == '0) begin
              done <= 1'b1;
            end else begin
              addr      <= base;
              remaining <= len;
              busy      <= 1'b1;
              state     <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue) begin
            addr      <= addr_nxt;
            remaining <= remaining - LW'(1);
            if (remaining == LW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_beat) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: stimulus queues expected words, a
// negedge monitor pops and compares every transferred beat.
module tb_mem_stream_reader;

  localparam int DEPTH = 9;
  localparam int AW    = 4;
  localparam int LW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic [AW-1:0] rdaddress;
  logic [7:0]    q;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;

  logic [7:0] mem [0:15];
  logic [7:0] exp_q [$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'd0;

  mem_stream_reader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdaddress (rdaddress),
    .q         (q),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
  end

  always @(posedge clock) q <= mem[rdaddress];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on every transfer, hold check on every stall.
  always @(negedge clock) begin
    if (done) done_cnt++;
    if (!reset && prev_stall) begin
      check("hold_valid", int'(m_valid), 1);
      check("hold_data", int'(m_data), int'(prev_dat));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_beat: got data %0d, expected no beat", m_data);
      end else begin
        check("beat_data", int'(m_data), int'(exp_q.pop_front()));
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_dat   = m_data;
  end

  // One command with fixed per-cycle expectations. Cycle k is the k-th clock
  // after the start cycle; m_ready is low for cycles rlo..rhi.
  task automatic run_directed(input string nm, input int b, input int l,
                              input int rlo, input int rhi,
                              input int vlo, input int vhi,
                              input int dcyc, input int ecyc);
    int d0;
    @(posedge clock); #1;
    start = 1'b1; base = AW'(b); len = LW'(l); m_ready = 1'b1;
    if (vlo > 0)
      for (int i = 0; i < l; i++) exp_q.push_back(8'(((b + i) % DEPTH) + 16));
    d0 = done_cnt;
    for (int k = 1; k <= dcyc + 2; k++) begin
      @(posedge clock); #1;
      start   = 1'b0;
      m_ready = !(k >= rlo && k <= rhi);
      if (k == 4 && dcyc > 5) begin
        start = 1'b1; base = '0; len = LW'(3);
      end
      @(negedge clock);
      check({nm, "_valid"}, int'(m_valid), int'(k >= vlo && k <= vhi));
      check({nm, "_done"},  int'(done),    int'(k == dcyc));
      check({nm, "_busy"},  int'(busy),    int'(k >= 1 && k < dcyc));
      check({nm, "_err"},   int'(err),     int'(k == ecyc));
      if (k == 1 && vlo > 0) check({nm, "_rdaddr"}, int'(rdaddress), b);
      if (!m_ready && k >= vlo && k <= vhi)
        check({nm, "_stall_data"}, int'(m_data), b + 16);
    end
    check({nm, "_done_once"}, done_cnt - d0, 1);
    check({nm, "_all_beats"}, exp_q.size(), 0);
  endtask

  initial begin
    int b, l, d0;
    bit finished;
    reset = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy",   int'(busy), 0);
    check("rst_done",   int'(done), 0);
    check("rst_err",    int'(err), 0);
    check("rst_valid",  int'(m_valid), 0);
    check("rst_rdaddr", int'(rdaddress), 0);
    check("rst_data",   int'(m_data), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // base=2 len=4: beats 18..21 in cycles 3-6, done in 7.
    run_directed("basic", 2, 4, 0, -1, 3, 6, 7, 0);
    // Same command, m_ready low cycles 3-8: beats resume at 9, done in 13.
    run_directed("stall", 2, 4, 3, 8, 3, 12, 13, 0);
    run_directed("len0", 5, 0, 0, -1, -1, -1, 1, 0);
`ifdef MEM_STREAM_READER_WRAP_EN
    // Beats 23,24,16,17.
    run_directed("wrap", 7, 4, 0, -1, 3, 6, 7, 0);
`else
    run_directed("reject", 7, 4, 0, -1, -1, -1, 1, 1);
`endif

    // Reset in cycle 4 of a len=6 run: beats 17,18 already delivered.
    @(posedge clock); #1;
    start = 1'b1; base = AW'(1); len = LW'(6); m_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(8'(17 + i));
    d0 = done_cnt;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("mid_rst_busy",   int'(busy), 0);
    check("mid_rst_done",   int'(done), 0);
    check("mid_rst_valid",  int'(m_valid), 0);
    check("mid_rst_rdaddr", int'(rdaddress), 0);
    check("mid_rst_data",   int'(m_data), 0);
    check("mid_rst_nodone", done_cnt - d0, 0);
    run_directed("after_rst", 4, 3, 0, -1, 3, 5, 6, 0);

    // Random commands with 50% m_ready.
    for (int c = 0; c < 200; c++) begin
      b = $urandom_range(0, DEPTH - 1);
`ifdef MEM_STREAM_READER_WRAP_EN
      l = $urandom_range(0, DEPTH);
`else
      l = $urandom_range(0, DEPTH - b);
`endif
      @(posedge clock); #1;
      start = 1'b1; base = AW'(b); len = LW'(l);
      m_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < l; i++) exp_q.push_back(8'(((b + i) % DEPTH) + 16));
      d0 = done_cnt;
      finished = 1'b0;
      for (int t = 0; t < 300 && !finished; t++) begin
        @(posedge clock); #1;
        start   = 1'b0;
        m_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        if (done) finished = 1'b1;
        if (err) begin
          total++;
          bad++;
          $display("FAIL rand_err: got err=1, expected 0 (cmd %0d)", c);
        end
      end
      if (!finished) begin
        total++;
        bad++;
        $display("FAIL rand_timeout: got no done, expected done (cmd %0d)", c);
      end
      @(posedge clock); #1;
      check("rand_done_once", done_cnt - d0, 1);
      check("rand_all_beats", exp_q.size(), 0);
      exp_q.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
